// File: rtl/gecko_acq_pkg.sv
// Shared types and constants for the triggered ADC frame capture path.
package gecko_acq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    ACQ,
    DONE
  } acq_state_t;

  localparam int unsigned SAMPLE_W       = 12;
  localparam int unsigned MAX_DECIM_LOG2 = 4;
  localparam int unsigned ACC_W          = SAMPLE_W + MAX_DECIM_LOG2;

  // Output word: two 16-bit lanes, each {pad, average}.
  localparam int unsigned LANE_W = 16;
  localparam int unsigned WORD_W = 2 * LANE_W;
  localparam logic [LANE_W-SAMPLE_W-1:0] LANE_PAD = '0;

  // Averaging depth beyond 2^MAX_DECIM_LOG2 would overflow the accumulator.
  function automatic logic [2:0] clamp_decim(input logic [2:0] k);
    return (k > 3'(MAX_DECIM_LOG2)) ? 3'(MAX_DECIM_LOG2) : k;
  endfunction

endpackage

// File: rtl/adc_avg_acc.sv
// Box-car accumulator for one channel; sample counter is owned by the parent.
module adc_avg_acc
  import gecko_acq_pkg::*;
#(
  parameter int unsigned DATA_W    = SAMPLE_W,
  parameter int unsigned ACC_WIDTH = ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        k,
  input  logic [3:0]        samp_cnt,
  input  logic [DATA_W-1:0] sample,
  output logic [DATA_W-1:0] avg,
  output logic              done
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sum;
  logic                 last;

  // Running sum including this cycle's sample, and end-of-word detection.
  always_comb begin
    sum  = acc + ACC_WIDTH'(sample);
    last = ({1'b0, samp_cnt} == ((5'd1 << k) - 5'd1));
    avg  = DATA_W'(sum >> k);
    done = en && last;
  end

  // Restart on the word boundary so the next sample begins a fresh sum.
  always_ff @(posedge clk) begin
    if (rst || !en || last) acc <= '0;
    else                    acc <= sum;
  end

endmodule

// File: rtl/adc_frame_capture.sv
// Triggered two-channel frame capture into a ping-pong readout buffer.
module adc_frame_capture
  import gecko_acq_pkg::*;
#(
  parameter int unsigned DATA_W = SAMPLE_W,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              adc_clk,
  input  logic              rst,
  input  logic              i_trig,
  input  logic [15:0]       i_delay,
  input  logic [2:0]        i_decim_log2,
  input  logic [ADDR_W:0]   i_len,
  input  logic [DATA_W-1:0] i_adc_data_0,
  input  logic [DATA_W-1:0] i_adc_data_1,
  input  logic              i_ack,
  input  logic              i_ack_bank,
  input  logic              i_clr_ovr,
  output logic              o_wr_en,
  output logic [ADDR_W:0]   o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_irq,
  output logic              o_half,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  acq_state_t        state;
  logic              trig_q;
  logic              trig_edge;
  logic [DATA_W-1:0] s0;
  logic [DATA_W-1:0] s1;
  logic [15:0]       delay_cnt;
  logic [2:0]        k_lat;
  logic [ADDR_W:0]   len_lat;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W:0]   word_idx;
  logic [3:0]        samp_cnt;
  logic              wr_bank;
  logic [1:0]        full;
  logic              acq_en;
  logic [DATA_W-1:0] avg0;
  logic [DATA_W-1:0] avg1;
  logic              done0;
  logic              done1;
  logic              word_done;

  // Trigger edge, frame length clamp and accumulator enable.
  always_comb begin
    trig_edge = i_trig && !trig_q;
    len_eff   = (i_len == '0 || i_len > FULL_LEN) ? FULL_LEN : i_len;
    acq_en    = (state == ACQ);
    // Both lanes share the sample counter, so their strobes always coincide.
    word_done = done0 && done1;
  end

  // Sample and trigger input registers.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      trig_q <= 1'b0;
      s0     <= '0;
      s1     <= '0;
    end else begin
      trig_q <= i_trig;
      s0     <= i_adc_data_0;
      s1     <= i_adc_data_1;
    end
  end

  adc_avg_acc #(
    .DATA_W    (DATA_W),
    .ACC_WIDTH (DATA_W + MAX_DECIM_LOG2)
  ) u_acc0 (
    .clk      (adc_clk),
    .rst      (rst),
    .en       (acq_en),
    .k        (k_lat),
    .samp_cnt (samp_cnt),
    .sample   (s0),
    .avg      (avg0),
    .done     (done0)
  );

  adc_avg_acc #(
    .DATA_W    (DATA_W),
    .ACC_WIDTH (DATA_W + MAX_DECIM_LOG2)
  ) u_acc1 (
    .clk      (adc_clk),
    .rst      (rst),
    .en       (acq_en),
    .k        (k_lat),
    .samp_cnt (samp_cnt),
    .sample   (s1),
    .avg      (avg1),
    .done     (done1)
  );

  // Frame FSM, bank bookkeeping and registered buffer-side outputs.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state     <= IDLE;
      delay_cnt <= '0;
      k_lat     <= '0;
      len_lat   <= '0;
      word_idx  <= '0;
      samp_cnt  <= '0;
      wr_bank   <= 1'b0;
      full      <= 2'b00;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_irq     <= 1'b0;
      o_half    <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_irq   <= 1'b0;
      o_wr_en <= word_done;
      if (word_done) begin
        o_wr_addr <= {wr_bank, word_idx[ADDR_W-1:0]};
        o_wr_data <= {LANE_PAD, avg1, LANE_PAD, avg0};
      end
      // Ack clears first so a DONE on the same bank in the same cycle wins.
      if (i_ack) full[i_ack_bank] <= 1'b0;
      if (i_clr_ovr) o_overrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (trig_edge) begin
            if (full[wr_bank]) begin
              o_overrun <= 1'b1;
            end else begin
              k_lat     <= clamp_decim(i_decim_log2);
              len_lat   <= len_eff;
              delay_cnt <= i_delay;
              word_idx  <= '0;
              samp_cnt  <= '0;
              o_busy    <= 1'b1;
              state     <= (i_delay == 16'd0) ? ACQ : DELAY;
            end
          end
        end
        DELAY: begin
          // Loaded with D; D cycles are spent here before ACQ.
          if (delay_cnt == 16'd1) state <= ACQ;
          else                    delay_cnt <= delay_cnt - 16'd1;
        end
        ACQ: begin
          if (word_done) samp_cnt <= '0;
          else           samp_cnt <= samp_cnt + 4'd1;
          if (word_done) begin
            word_idx <= word_idx + 1'b1;
            if (word_idx + 1'b1 == len_lat) state <= DONE;
          end
        end
        DONE: begin
          full[wr_bank] <= 1'b1;
          o_half        <= wr_bank;
          o_irq         <= 1'b1;
          wr_bank       <= ~wr_bank;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/adc_frame_capture.md
# adc_frame_capture

Triggered two-channel acquisition stage between the ADC inputs (d0x/d1x, on `adc_clk`) and the ESP32 readout buffer. On a trigger edge it waits a programmable delay, then captures a frame from both channels. Each output word is the box-car average of 2^k samples. Words go into one bank of a two-bank (ping-pong) buffer. When a frame completes, it raises the ESP interrupt pulse and the bank flag (esp_sync / esp_half).

## Interface
Parameters:
- `DATA_W`, 12: ADC sample width.
- `ADDR_W`, 9: word address width per bank (512 words).

Ports:
- `adc_clk` in 1: the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `i_trig` in 1: trigger level, already synchronous to `adc_clk`; the block acts on its rising edge.
- `i_delay` in 16: cycles from trigger edge to first sample.
- `i_decim_log2` in 3: k, averaging 2^k samples per word; values above 4 clamp to 4.
- `i_len` in ADDR_W+1: words per frame; 0 means 2^ADDR_W; values above 2^ADDR_W clamp to 2^ADDR_W.
- `i_adc_data_0`, `i_adc_data_1` in DATA_W: raw channel samples.
- `i_ack` in 1: one-cycle pulse; the consumer has finished reading bank `i_ack_bank`.
- `i_ack_bank` in 1: bank released by `i_ack`.
- `i_clr_ovr` in 1: clears `o_overrun`.
- `o_wr_en` out 1: buffer write strobe.
- `o_wr_addr` out ADDR_W+1: {bank, word index}.
- `o_wr_data` out 32: {4'h0, avg1, 4'h0, avg0}.
- `o_irq` out 1: one-cycle frame-done pulse (to esp_sync).
- `o_half` out 1: bank index of the last completed frame (to esp_half).
- `o_busy` out 1: high in DELAY, ACQ and DONE.
- `o_overrun` out 1: sticky; a trigger was dropped because the target bank was still full.

## Operation
- Samples are registered once (`s0`, `s1` ← inputs every cycle), and the accumulators use only the registered values.
- FSM states:
  - IDLE: on a trigger rising edge, check `full[wr_bank]`.
    - If the bank is full, set `o_overrun` and stay in IDLE.
    - Otherwise latch `i_delay`, clamped k and effective length L, then go to DELAY.
  - DELAY: a down-counter runs from the latched delay. When it reaches 0, go to ACQ.
  - ACQ: add `s0`/`s1` into 16-bit accumulators each cycle.
    - After 2^k samples, write (sum >> k) truncated to 12 bits and restart the accumulators on the next sample, with no gap.
    - When the word index reaches L, go to DONE.
  - DONE: set `full[wr_bank]`, set `o_half` ← `wr_bank`, pulse `o_irq`, toggle `wr_bank`, go to IDLE.
- Trigger edges outside IDLE are ignored and do not set `o_overrun`.
- `i_ack` clears `full[i_ack_bank]`. Acking a bank that is not full has no effect.
- The IDLE full-check uses the registered `full` flags. A trigger coinciding with the ack that frees the target bank is therefore dropped and sets `o_overrun`.
- If `i_clr_ovr` and an overrun event occur in the same cycle, the set wins.
- Arithmetic: unsigned; the accumulator is DATA_W+4 bits and cannot overflow for k ≤ 4; averages are truncated, not rounded.

## Timing
- Trigger edge in cycle t → DELAY entered at t+1.
- With `i_delay`=D, ACQ is entered at t+1+D; D=0 enters ACQ at t+1 directly.
- Word n (0-based) covers ACQ cycles n·2^k … n·2^k+2^k−1. `o_wr_en` is asserted in the cycle after the last of those, with `o_wr_addr` = {wr_bank, n}.
- Strobes are contiguous when k=0.
- The last word's write happens in the DONE cycle. `o_irq` and the new `o_half` appear in the following cycle (registered).
- One frame occupies L·2^k ACQ cycles; the minimum re-arm gap after `o_irq` is 0 cycles.
- Reset values: all outputs 0, FSM in IDLE, `wr_bank`=0, `full`=2'b00, accumulators 0.
- Reset mid-frame abandons the frame: no `o_irq`, and no bank is marked full.

## Structure
- Package `gecko_acq_pkg` holds:
  - the FSM state enum (IDLE, DELAY, ACQ, DONE);
  - `ACC_W` = DATA_W+4;
  - `MAX_DECIM_LOG2` = 4;
  - the output word packing constants.
- Sub-module `adc_avg_acc`, one per channel (two instances). It contains the accumulator, the sample counter compare, the shift-by-k and the done strobe, and shares k and the counter with the parent.

## Test plan
- **k=0, D=0, L=4, s0=12'h123, s1=12'h456 constant:** 4 consecutive writes at addr 0..3 with data 32'h0456_0123. `o_irq` one cycle after the last write, `o_half`=0, `full`=01.
- **k=2, D=10, ramp input 0,1,2,…:** first write 11+4 cycles after the trigger edge with avg0 = (0+1+2+3)>>2 = 1. Next average is 5.
- **Two frames with no ack:** second frame goes to bank 1 (addr MSB=1) and `o_half`=1. A third trigger sets `o_overrun` and produces no writes.
- **Ack bank 0 before the third trigger:** the third frame writes bank 0. Ack coinciding with the trigger → overrun.
- **`i_len`=0, k=0:** 512 writes.
- **`i_decim_log2`=7:** behaves as k=4 with no accumulator overflow at input 12'hFFF (avg=FFF).
- **`rst` asserted during ACQ:** outputs go to 0 next cycle, no `o_irq`. A new trigger then writes bank 0 from addr 0.
